// File: rtl/systolic_pkg.sv
// Shared encodings, widths and FSM state type for the 2x2 systolic MAC tile.
package systolic_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 64;

  localparam logic [2:0] DT_UINT32 = 3'b011;
  localparam logic [2:0] DT_INT32  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL,
    ST_ACC
  } state_t;

  // Only the signed encoding selects signed arithmetic; anything else is unsigned.
  function automatic logic is_signed_mode(input logic [2:0] dt);
    return dt == DT_INT32;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: operand registers, product register,
// 64-bit accumulator and sticky overflow flag.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter logic [2:0] DATA_TYPE = DT_UINT32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              mul_en,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] i_row,
  input  logic [DATA_W-1:0] i_col,
  output logic [DATA_W-1:0] o_row,
  output logic [DATA_W-1:0] o_col,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_carry
);

  localparam logic SIGNED_MODE = is_signed_mode(DATA_TYPE);

  logic [DATA_W-1:0] r_row;
  logic [DATA_W-1:0] r_col;
  logic [ACC_W-1:0]  r_prod;
  logic [ACC_W-1:0]  r_acc;
  logic              r_carry;

  logic [ACC_W-1:0]  w_a;
  logic [ACC_W-1:0]  w_b;
  logic [ACC_W-1:0]  w_prod;
  logic [ACC_W-1:0]  w_sum;
  logic              w_cout;
  logic              w_ovf;

  // The low 64 bits of a product of extended operands is the exact full product.
  assign w_a    = SIGNED_MODE ? {{DATA_W{r_row[DATA_W-1]}}, r_row} : {{DATA_W{1'b0}}, r_row};
  assign w_b    = SIGNED_MODE ? {{DATA_W{r_col[DATA_W-1]}}, r_col} : {{DATA_W{1'b0}}, r_col};
  assign w_prod = w_a * w_b;

  assign {w_cout, w_sum} = {1'b0, r_acc} + {1'b0, r_prod};
  assign w_ovf = SIGNED_MODE ?
                 ((r_acc[ACC_W-1] == r_prod[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1])) :
                 w_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else begin
      if (shift_en) begin
        r_row <= i_row;
        r_col <= i_col;
      end
      if (mul_en) begin
        r_prod <= w_prod;
      end
      if (acc_en) begin
        r_acc   <= w_sum;
        r_carry <= r_carry | w_ovf;
      end
    end
  end

  assign o_row    = r_row;
  assign o_col    = r_col;
  assign o_result = r_acc;
  assign o_carry  = r_carry;

endmodule

// File: rtl/systolic_2x2.sv
// 2x2 output-stationary systolic MAC array: step FSM, done pulse and PE mesh.
module systolic_2x2
  import systolic_pkg::*;
#(
  parameter logic [2:0] DATA_TYPE = DT_UINT32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_in,
  input  logic [DATA_W-1:0] row_in_row0,
  input  logic [DATA_W-1:0] row_in_row1,
  input  logic [DATA_W-1:0] col_in_col0,
  input  logic [DATA_W-1:0] col_in_col1,
  output logic [ACC_W-1:0]  result_row00,
  output logic [ACC_W-1:0]  result_row01,
  output logic [ACC_W-1:0]  result_row10,
  output logic [ACC_W-1:0]  result_row11,
  output logic              carry_00,
  output logic              carry_01,
  output logic              carry_10,
  output logic              carry_11,
  output logic              done
);

  state_t r_state;
  state_t w_next;
  logic   r_done;
  logic   w_shift_en;
  logic   w_mul_en;
  logic   w_acc_en;

  // Requests arriving outside IDLE are dropped, not queued.
  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_mul_en   = 1'b0;
    w_acc_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_in) begin
          w_shift_en = 1'b1;
          w_next     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_mul_en = 1'b1;
        w_next   = ST_MUL;
      end
      ST_MUL: begin
        w_acc_en = 1'b1;
        w_next   = ST_ACC;
      end
      ST_ACC: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_acc_en;
    end
  end

  assign done = r_done;

  logic [DATA_W-1:0] w_row_fwd0;
  logic [DATA_W-1:0] w_row_fwd1;
  logic [DATA_W-1:0] w_col_fwd0;
  logic [DATA_W-1:0] w_col_fwd1;
  logic [DATA_W-1:0] w_row_unused0;
  logic [DATA_W-1:0] w_row_unused1;
  logic [DATA_W-1:0] w_col_unused0;
  logic [DATA_W-1:0] w_col_unused1;

  systolic_pe #(.DATA_TYPE(DATA_TYPE)) u_pe00 (
    .clk(clk), .rst(rst), .shift_en(w_shift_en), .mul_en(w_mul_en), .acc_en(w_acc_en),
    .i_row(row_in_row0), .i_col(col_in_col0),
    .o_row(w_row_fwd0), .o_col(w_col_fwd0),
    .o_result(result_row00), .o_carry(carry_00)
  );

  systolic_pe #(.DATA_TYPE(DATA_TYPE)) u_pe01 (
    .clk(clk), .rst(rst), .shift_en(w_shift_en), .mul_en(w_mul_en), .acc_en(w_acc_en),
    .i_row(w_row_fwd0), .i_col(col_in_col1),
    .o_row(w_row_unused0), .o_col(w_col_fwd1),
    .o_result(result_row01), .o_carry(carry_01)
  );

  systolic_pe #(.DATA_TYPE(DATA_TYPE)) u_pe10 (
    .clk(clk), .rst(rst), .shift_en(w_shift_en), .mul_en(w_mul_en), .acc_en(w_acc_en),
    .i_row(row_in_row1), .i_col(w_col_fwd0),
    .o_row(w_row_fwd1), .o_col(w_col_unused0),
    .o_result(result_row10), .o_carry(carry_10)
  );

  systolic_pe #(.DATA_TYPE(DATA_TYPE)) u_pe11 (
    .clk(clk), .rst(rst), .shift_en(w_shift_en), .mul_en(w_mul_en), .acc_en(w_acc_en),
    .i_row(w_row_fwd1), .i_col(w_col_fwd1),
    .o_row(w_row_unused1), .o_col(w_col_unused1),
    .o_result(result_row11), .o_carry(carry_11)
  );

endmodule

// File: tb/tb_systolic_2x2.sv
// Directed self-checking bench for systolic_2x2 (unsigned and signed instances).
module tb_systolic_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_in;
  logic [31:0] row0, row1, col0, col1;
  logic [63:0] res00, res01, res10, res11;
  logic        c00, c01, c10, c11, done;
  logic [63:0] sRes00, sRes01, sRes10, sRes11;
  logic        sC00, sC01, sC10, sC11, sDone;

  int total = 0;
  int bad = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  systolic_2x2 u_dut (
    .clk(clk), .rst(rst), .load_in(load_in),
    .row_in_row0(row0), .row_in_row1(row1), .col_in_col0(col0), .col_in_col1(col1),
    .result_row00(res00), .result_row01(res01), .result_row10(res10), .result_row11(res11),
    .carry_00(c00), .carry_01(c01), .carry_10(c10), .carry_11(c11), .done(done)
  );

  systolic_2x2 #(.DATA_TYPE(3'b100)) u_dut_s (
    .clk(clk), .rst(rst), .load_in(load_in),
    .row_in_row0(row0), .row_in_row1(row1), .col_in_col0(col0), .col_in_col1(col1),
    .result_row00(sRes00), .result_row01(sRes01), .result_row10(sRes10), .result_row11(sRes11),
    .carry_00(sC00), .carry_01(sC01), .carry_10(sC10), .carry_11(sC11), .done(sDone)
  );

  always @(negedge clk) if (done === 1'b1) doneCount++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zeroInputs();
    row0 = '0; row1 = '0; col0 = '0; col1 = '0;
  endtask

  task automatic doReset();
    rst = 1'b1; load_in = 1'b0; zeroInputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic doStep(input logic [31:0] r0, r1, c0, c1);
    row0 = r0; row1 = r1; col0 = c0; col1 = c1; load_in = 1'b1;
    tick();
    load_in = 1'b0; zeroInputs();
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    int d0;
    // load_in asserted during reset must be overridden
    rst = 1'b1; load_in = 1'b1; row0 = 32'd5; col0 = 32'd5; row1 = '0; col1 = '0;
    tick(); tick();
    rst = 1'b0; load_in = 1'b0; zeroInputs();
    total++;
    if ({res00, res01, res10, res11} !== 256'd0) begin
      bad++; $display("[TB] FAIL reset_results got=%h %h %h %h exp=0", res00, res01, res10, res11);
    end
    total++;
    if ({c00, c01, c10, c11, done} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=00000", {c00, c01, c10, c11, done});
    end
    d0 = doneCount;
    tick();
    total++;
    if (done !== 1'b0 || doneCount != d0) begin
      bad++; $display("[TB] FAIL reset_priority done=%b count=%0d exp no done", done, doneCount - d0);
    end
    doStep(0, 0, 0, 0);
    doStep(0, 0, 0, 0);
    total++;
    if ({res00, res01, res10, res11} !== 256'd0) begin
      bad++; $display("[TB] FAIL zero_steps got=%h %h %h %h exp=0", res00, res01, res10, res11);
    end
    total++;
    if (doneCount - d0 != 2) begin
      bad++; $display("[TB] FAIL zero_steps_done got=%0d exp=2", doneCount - d0);
    end
  endtask

  task automatic test_matrix();
    logic [31:0] tr0 [4] = '{32'd2, 32'd1, 32'd0, 32'd0};
    logic [31:0] tr1 [4] = '{32'd0, 32'd4, 32'd3, 32'd0};
    logic [31:0] tc0 [4] = '{32'd3, 32'd1, 32'd0, 32'd0};
    logic [31:0] tc1 [4] = '{32'd0, 32'd4, 32'd2, 32'd0};
    logic [3:0] seenDone;
    int d0;
    doReset();
    d0 = doneCount;
    for (int s = 0; s < 4; s++) begin
      row0 = tr0[s]; row1 = tr1[s]; col0 = tc0[s]; col1 = tc1[s]; load_in = 1'b1;
      tick();
      load_in = 1'b0; zeroInputs();
      seenDone[0] = done;
      tick(); seenDone[1] = done;
      tick(); seenDone[2] = done;
      tick(); seenDone[3] = done;
      total++;
      if (seenDone !== 4'b0100) begin
        bad++; $display("[TB] FAIL done_timing step=%0d got=%b exp=0100", s, seenDone);
      end
    end
    total++;
    if (res00 !== 64'd7 || res01 !== 64'd10) begin
      bad++; $display("[TB] FAIL matrix_row0 got=%0d,%0d exp=7,10", res00, res01);
    end
    total++;
    if (res10 !== 64'd15 || res11 !== 64'd22) begin
      bad++; $display("[TB] FAIL matrix_row1 got=%0d,%0d exp=15,22", res10, res11);
    end
    total++;
    if ({c00, c01, c10, c11} !== 4'b0) begin
      bad++; $display("[TB] FAIL matrix_carry got=%b exp=0000", {c00, c01, c10, c11});
    end
    total++;
    if (doneCount - d0 != 4) begin
      bad++; $display("[TB] FAIL matrix_done_count got=%0d exp=4", doneCount - d0);
    end
  endtask

  task automatic test_busy();
    int d0;
    doReset();
    d0 = doneCount;
    row0 = 32'd2; col0 = 32'd3; load_in = 1'b1;
    tick(); tick(); tick();
    load_in = 1'b0; zeroInputs();
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (doneCount - d0 != 1) begin
      bad++; $display("[TB] FAIL busy_done_count got=%0d exp=1", doneCount - d0);
    end
    total++;
    if (res00 !== 64'd6 || res01 !== 64'd0) begin
      bad++; $display("[TB] FAIL busy_result got=%0d,%0d exp=6,0", res00, res01);
    end
  endtask

  task automatic test_overflow();
    doReset();
    doStep(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
    total++;
    if (res00 !== 64'hFFFF_FFFE_0000_0001 || c00 !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_first got=%h c=%b exp=fffffffe00000001 c=0", res00, c00);
    end
    doStep(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
    total++;
    if (res00 !== 64'hFFFF_FFFC_0000_0002) begin
      bad++; $display("[TB] FAIL ovf_result got=%h exp=fffffffc00000002", res00);
    end
    total++;
    if ({c00, c01, c10, c11} !== 4'b1000) begin
      bad++; $display("[TB] FAIL ovf_carry got=%b exp=1000", {c00, c01, c10, c11});
    end
  endtask

  task automatic test_signed();
    doReset();
    doStep(32'hFFFF_FFFF, 0, 32'd2, 0);
    total++;
    if (sRes00 !== 64'hFFFF_FFFF_FFFF_FFFE || sC00 !== 1'b0) begin
      bad++; $display("[TB] FAIL signed_result got=%h c=%b exp=fffffffffffffffe c=0", sRes00, sC00);
    end
    total++;
    if (res00 !== 64'h0000_0001_FFFF_FFFE || c00 !== 1'b0) begin
      bad++; $display("[TB] FAIL unsigned_same_ops got=%h c=%b exp=00000001fffffffe c=0", res00, c00);
    end
  endtask

  task automatic test_rst_mid();
    int d0;
    doReset();
    doStep(32'd2, 0, 32'd3, 0);
    total++;
    if (res00 !== 64'd6) begin
      bad++; $display("[TB] FAIL mid_pre got=%0d exp=6", res00);
    end
    d0 = doneCount;
    row0 = 32'd5; col0 = 32'd6; load_in = 1'b1;
    tick();
    load_in = 1'b0; zeroInputs(); rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (doneCount != d0) begin
      bad++; $display("[TB] FAIL mid_no_done got=%0d exp=0", doneCount - d0);
    end
    total++;
    if ({res00, res01, res10, res11} !== 256'd0 || {c00, c01, c10, c11} !== 4'b0) begin
      bad++; $display("[TB] FAIL mid_cleared got=%h %h %h %h exp=0", res00, res01, res10, res11);
    end
    doStep(32'd5, 0, 32'd6, 0);
    total++;
    if (res00 !== 64'd30 || doneCount - d0 != 1) begin
      bad++; $display("[TB] FAIL mid_recover got=%0d dones=%0d exp=30 dones=1", res00, doneCount - d0);
    end
  endtask

  initial begin
    rst = 1'b1; load_in = 1'b0;
    row0 = '0; row1 = '0; col0 = '0; col1 = '0;
    test_reset();
    test_matrix();
    test_busy();
    test_overflow();
    test_signed();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
